// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return o[0];
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_seq_if #(parameter int unsigned WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             hiwrite;
  logic             lowrite;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, hiwrite, lowrite, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, hiwrite, lowrite, wd,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_seq_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) iteration
// around a single WIDTH-bit adder with carry.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] low,
  input  logic             mode,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] low_next
);

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             cin;
  logic             cout;

  always_comb begin
    add_a    = acc;
    add_b    = '0;
    cin      = 1'b0;
    acc_next = acc;
    low_next = low;

    if (mode) begin
      add_a = {acc[WIDTH-2:0], low[WIDTH-1]};
      add_b = ~operand;
      cin   = 1'b1;
    end else begin
      add_b = low[0] ? operand : '0;
    end

    {cout, sum} = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(cin);

    if (mode) begin
      // Bit shifted out of the remainder counts as an extra carry for large divisors.
      if (cout | acc[WIDTH-1]) begin
        acc_next = sum;
        low_next = {low[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = add_a;
        low_next = {low[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {cout, sum[WIDTH-1:1]};
      low_next = {sum[0], low[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO writes.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic           ph1,
  input  logic           reset,
  muldiv_seq_if.slave    bus
);

  state_e           state, state_nxt;
  op_e              op_q, op_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;
  logic             negres, negres_nxt;
  logic             negrem, negrem_nxt;
  logic             divzero, divzero_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] low, low_nxt;
  logic [WIDTH-1:0] opnd, opnd_nxt;
  logic [WIDTH-1:0] hi_q, hi_nxt;
  logic [WIDTH-1:0] lo_q, lo_nxt;
  logic             done_q, done_nxt;
  logic             busy_q, busy_nxt;

  op_e                op_in;
  logic               sgn_in;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_low;
  logic               is_div;

  assign op_in  = op_e'(bus.op);
  assign is_div = op_is_div(op_q);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .low      (low),
    .mode     (is_div),
    .acc_next (step_acc),
    .low_next (step_low)
  );

  // State and datapath registers.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= OP_MULTU;
      cnt     <= '0;
      negres  <= 1'b0;
      negrem  <= 1'b0;
      divzero <= 1'b0;
      acc     <= '0;
      low     <= '0;
      opnd    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      cnt     <= cnt_nxt;
      negres  <= negres_nxt;
      negrem  <= negrem_nxt;
      divzero <= divzero_nxt;
      acc     <= acc_nxt;
      low     <= low_nxt;
      opnd    <= opnd_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      done_q  <= done_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Next-state, operand capture, iteration and sign fix-up.
  always_comb begin
    state_nxt   = state;
    op_nxt      = op_q;
    cnt_nxt     = cnt;
    negres_nxt  = negres;
    negrem_nxt  = negrem;
    divzero_nxt = divzero;
    acc_nxt     = acc;
    low_nxt     = low;
    opnd_nxt    = opnd;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    done_nxt    = 1'b0;
    sgn_in      = op_is_signed(op_in);
    a_mag       = (sgn_in && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
    b_mag       = (sgn_in && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
    prod        = negres ? -{acc, low} : {acc, low};

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt   = S_RUN;
          op_nxt      = op_in;
          cnt_nxt     = '0;
          negres_nxt  = sgn_in & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
          negrem_nxt  = sgn_in & bus.srca[WIDTH-1];
          divzero_nxt = op_is_div(op_in) && (bus.srcb == '0);
          acc_nxt     = '0;
          if (op_is_div(op_in)) begin
            low_nxt  = a_mag;
            opnd_nxt = b_mag;
          end else begin
            low_nxt  = b_mag;
            opnd_nxt = a_mag;
          end
        end else begin
          if (bus.hiwrite) hi_nxt = bus.wd;
          if (bus.lowrite) lo_nxt = bus.wd;
        end
      end

      S_RUN: begin
        acc_nxt = step_acc;
        low_nxt = step_low;
        cnt_nxt = cnt + CNTW'(1);
        if (cnt == CNTW'(WIDTH - 1)) state_nxt = S_FIX;
      end

      S_FIX: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
        if (is_div) begin
          // Negating |dividend| restores the raw dividend, which also covers divide by zero.
          hi_nxt = negrem ? -acc : acc;
          lo_nxt = (negres && !divzero) ? -low : low;
        end else begin
          hi_nxt = prod[2*WIDTH-1:WIDTH];
          lo_nxt = prod[WIDTH-1:0];
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
